// File: rtl/input_conditioner.sv
// Push-button and slide-switch conditioner: 2-flop synchronizers, button debounce FSM with
// one-shot press pulse, and an 8-bit switch debouncer with an update pulse.
module input_conditioner #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  input  logic [7:0] switch_raw,
  output logic       button,
  output logic       button_level,
  output logic [7:0] switch,
  output logic       switch_changed
);

  localparam logic [19:0] CntMax = 20'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } btn_state_e;

  logic       b_meta;
  logic       b_s;
  logic [7:0] sw_meta;
  logic [7:0] sw_s;

  btn_state_e  btn_state;
  logic [19:0] btn_cnt;

  logic [7:0]  sw_cand;
  logic [19:0] sw_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_meta  <= 1'b0;
      b_s     <= 1'b0;
      sw_meta <= 8'h00;
      sw_s    <= 8'h00;
    end else begin
      b_meta  <= button_raw;
      b_s     <= b_meta;
      sw_meta <= switch_raw;
      sw_s    <= sw_meta;
    end
  end

  // The press pulse and level are registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_state    <= StIdle;
      btn_cnt      <= 20'd0;
      button       <= 1'b0;
      button_level <= 1'b0;
    end else begin
      button <= 1'b0;
      unique case (btn_state)
        StIdle: begin
          if (b_s) begin
            btn_state <= StPressWait;
            btn_cnt   <= 20'd1;
          end
        end
        StPressWait: begin
          if (!b_s) begin
            btn_state <= StIdle;
            btn_cnt   <= 20'd0;
          end else if (btn_cnt == CntMax) begin
            btn_state    <= StHeld;
            btn_cnt      <= 20'd0;
            button       <= 1'b1;
            button_level <= 1'b1;
          end else begin
            btn_cnt <= btn_cnt + 20'd1;
          end
        end
        StHeld: begin
          if (!b_s) begin
            btn_state <= StReleaseWait;
            btn_cnt   <= 20'd1;
          end
        end
        StReleaseWait: begin
          // A bounce back high returns to HELD silently; no second pulse.
          if (b_s) begin
            btn_state <= StHeld;
            btn_cnt   <= 20'd0;
          end else if (btn_cnt == CntMax) begin
            btn_state    <= StIdle;
            btn_cnt      <= 20'd0;
            button_level <= 1'b0;
          end else begin
            btn_cnt <= btn_cnt + 20'd1;
          end
        end
        default: begin
          btn_state <= StIdle;
          btn_cnt   <= 20'd0;
        end
      endcase
    end
  end

  // Any change of the synchronized vector restarts qualification from the new candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_cand        <= 8'h00;
      sw_cnt         <= 20'd0;
      switch         <= 8'h00;
      switch_changed <= 1'b0;
    end else begin
      switch_changed <= 1'b0;
      if (sw_s != sw_cand) begin
        sw_cand <= sw_s;
        sw_cnt  <= 20'd1;
      end else if (sw_cand != switch) begin
        if (sw_cnt == CntMax) begin
          switch         <= sw_cand;
          switch_changed <= 1'b1;
          sw_cnt         <= 20'd0;
        end else begin
          sw_cnt <= sw_cnt + 20'd1;
        end
      end else begin
        sw_cnt <= 20'd0;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEB_CYCLES=4; edge n is the n-th rising clock edge
// after stimulus is applied, and outputs are sampled 1 time unit after that edge.
module tb_input_conditioner;

  localparam int unsigned Deb = 4;

  logic       clk;
  logic       rst;
  logic       button_raw;
  logic [7:0] switch_raw;
  logic       button;
  logic       button_level;
  logic [7:0] switch;
  logic       switch_changed;

  int n_checks;
  int n_fail;

  input_conditioner #(
    .DEB_CYCLES(Deb)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .button_raw     (button_raw),
    .switch_raw     (switch_raw),
    .button         (button),
    .button_level   (button_level),
    .switch         (switch),
    .switch_changed (switch_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " button"}, 32'(button), 32'd0);
    check({tag, " level"}, 32'(button_level), 32'd0);
    check({tag, " switch"}, 32'(switch), 32'd0);
    check({tag, " changed"}, 32'(switch_changed), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst        = 1'b1;
    button_raw = 1'b0;
    switch_raw = 8'h00;
    repeat (2) tick();
    check_zero(tag);
    rst = 1'b0;
  endtask

  int btn_pulses;
  int sw_pulses;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    button_raw = 1'b0;
    switch_raw = 8'h00;

    // Press held 20 edges then released: pulse on edge 6, level over edges 6..25.
    do_reset("rst1");
    button_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 20) button_raw = 1'b0;
      check($sformatf("press e%0d btn", e), 32'(button), 32'(e == 6));
      check($sformatf("press e%0d lvl", e), 32'(button_level), 32'(e >= 6 && e <= 25));
    end

    // Bouncy press 1,1,0,1,1,1,0,1 then held; later a 2-edge release bounce.
    do_reset("rst2");
    for (int e = 1; e <= 30; e++) begin
      button_raw = !(e == 3 || e == 7 || e == 21 || e == 22);
      tick();
      check($sformatf("bounce e%0d btn", e), 32'(button), 32'(e == 13));
      check($sformatf("bounce e%0d lvl", e), 32'(button_level), 32'(e >= 13));
    end

    // Switch 0x00 -> 0xA5 held: update and pulse on edge 6.
    do_reset("rst3");
    switch_raw = 8'hA5;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("swA5 e%0d sw", e), 32'(switch), (e >= 6) ? 32'hA5 : 32'h00);
      check($sformatf("swA5 e%0d chg", e), 32'(switch_changed), 32'(e == 6));
    end

    // Short glitch to 0x01 for two samples: no update, no pulse.
    do_reset("rst4");
    switch_raw = 8'h01;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 2) switch_raw = 8'h00;
      check($sformatf("glitch e%0d sw", e), 32'(switch), 32'h00);
      check($sformatf("glitch e%0d chg", e), 32'(switch_changed), 32'd0);
    end

    // Staggered settle: 0x01 on edge 1, 0x03 from edge 3; single update on edge 8.
    do_reset("rst5");
    switch_raw = 8'h01;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 2) switch_raw = 8'h03;
      check($sformatf("stagger e%0d sw", e), 32'(switch), (e >= 8) ? 32'h03 : 32'h00);
      check($sformatf("stagger e%0d chg", e), 32'(switch_changed), 32'(e == 8));
    end

    // Reset pulsed mid-debounce with the button held: requalify from zero.
    do_reset("rst6");
    button_raw = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    for (int p = 1; p <= 15; p++) begin
      tick();
      check($sformatf("postrst p%0d btn", p), 32'(button), 32'(p == 6));
      check($sformatf("postrst p%0d lvl", p), 32'(button_level), 32'(p >= 6));
    end

    // Long press concurrent with a switch change 0x3C -> 0xC3.
    do_reset("rst7");
    switch_raw = 8'h3C;
    repeat (10) tick();
    check("pre sw", 32'(switch), 32'h3C);
    button_raw = 1'b1;
    switch_raw = 8'hC3;
    btn_pulses = 0;
    sw_pulses  = 0;
    for (int e = 1; e <= 110; e++) begin
      tick();
      if (e == 100) button_raw = 1'b0;
      if (button) btn_pulses++;
      if (switch_changed) sw_pulses++;
    end
    check("concur btn pulses", 32'(btn_pulses), 32'd1);
    check("concur sw pulses", 32'(sw_pulses), 32'd1);
    check("concur sw", 32'(switch), 32'hC3);
    check("concur lvl", 32'(button_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
